// File: rtl/branch_resolve.sv
// branch_resolve
//   Resolves the conditional branch sitting in the execute stage. Holds an
//   ID/EX record of the branch (valid, funct3, fetch prediction, alternate
//   PC), evaluates the condition against the forwarded operands, and issues
//   a single mispredict redirect to fetch even when EX is held for several
//   cycles. Also keeps saturating counts of resolved and mispredicted
//   branches.
//
//   Handshake: there is no valid/ready pair here. The ID/EX record advances
//   whenever ex_stall is low and holds while it is high; ex_branch_flush is a
//   one-cycle pulse that fetch must act on in the cycle it is seen.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   id_is_branch        decode-stage instruction is a conditional branch
//   id_funct3           decode-stage branch funct3
//   id_branch_taken     fetch prediction for the decode-stage branch
//   id_branch_nt_pc     alternate PC (the path fetch did not follow)
//   intrlock_bubble     interlock: bubble into EX instead of decode instr
//   ex_stall            execute stage held this cycle
//   ex_rs1_val/rs2_val  forwarded operands of the EX instruction
//   stat_clr            synchronous clear of the statistics counters
//   ex_branch_flush     mispredict redirect pulse
//   ex_branch_pc        redirect PC (alt_pc while a branch is valid, else 0)
//   ex_branch_taken     resolved outcome of the valid EX branch
//   ex_br_illegal       valid EX branch with reserved funct3 (010/011)
//   stat_br_cnt         resolved-branch count (saturating)
//   stat_mis_cnt        mispredict count (saturating)
module branch_resolve (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_is_branch,
  input  logic [2:0]  id_funct3,
  input  logic        id_branch_taken,
  input  logic [31:0] id_branch_nt_pc,
  input  logic        intrlock_bubble,
  input  logic        ex_stall,
  input  logic [31:0] ex_rs1_val,
  input  logic [31:0] ex_rs2_val,
  input  logic        stat_clr,
  output logic        ex_branch_flush,
  output logic [31:0] ex_branch_pc,
  output logic        ex_branch_taken,
  output logic        ex_br_illegal,
  output logic [15:0] stat_br_cnt,
  output logic [15:0] stat_mis_cnt
);

  // PEND: the EX branch may still raise its redirect.
  // DONE: the redirect opportunity has been used while EX is held.
  typedef enum logic {
    ST_PEND = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t      state;
  logic        vld;
  logic [2:0]  funct3;
  logic        pred;
  logic [31:0] alt_pc;

  logic        cond;
  logic        illegal;
  logic        mispredict;
  logic        retire;

  // Branch condition over the full 32-bit operands.
  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      3'b000:  cond = (ex_rs1_val == ex_rs2_val);
      3'b001:  cond = (ex_rs1_val != ex_rs2_val);
      3'b100:  cond = ($signed(ex_rs1_val) <  $signed(ex_rs2_val));
      3'b101:  cond = ($signed(ex_rs1_val) >= $signed(ex_rs2_val));
      3'b110:  cond = (ex_rs1_val <  ex_rs2_val);
      3'b111:  cond = (ex_rs1_val >= ex_rs2_val);
      default: illegal = 1'b1;  // 010 / 011 are reserved
    endcase
  end

  assign mispredict      = (cond != pred);
  assign ex_branch_taken = vld & cond;
  assign ex_br_illegal   = vld & illegal;
  assign ex_branch_pc    = vld ? alt_pc : 32'd0;
  // Only the first EX cycle (PEND) may redirect; later held cycles are DONE.
  assign ex_branch_flush = vld & ~illegal & mispredict & (state == ST_PEND);
  // A legal branch leaves EX when the stage is not held.
  assign retire          = vld & ~illegal & ~ex_stall;

  // ID/EX record. The flush squashes the decode-stage instruction, and it
  // does so regardless of the interlock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld    <= 1'b0;
      funct3 <= 3'b000;
      pred   <= 1'b0;
      alt_pc <= 32'd0;
    end else if (!ex_stall) begin
      vld    <= id_is_branch & ~ex_branch_flush & ~intrlock_bubble;
      funct3 <= id_funct3;
      pred   <= id_branch_taken;
      alt_pc <= id_branch_nt_pc;
    end
  end

  // Redirect-once tracker: every load re-arms it, a held valid branch
  // consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PEND;
    end else if (!ex_stall) begin
      state <= ST_PEND;
    end else if (vld) begin
      state <= ST_DONE;
    end
  end

  // Statistics: clear wins over increment, both saturate at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_cnt  <= 16'd0;
      stat_mis_cnt <= 16'd0;
    end else if (stat_clr) begin
      stat_br_cnt  <= 16'd0;
      stat_mis_cnt <= 16'd0;
    end else if (retire) begin
      if (stat_br_cnt != 16'hFFFF) begin
        stat_br_cnt <= stat_br_cnt + 16'd1;
      end
      if (mispredict && (stat_mis_cnt != 16'hFFFF)) begin
        stat_mis_cnt <= stat_mis_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Testbench for branch_resolve: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_branch_resolve;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  logic        id_is_branch;
  logic [2:0]  id_funct3;
  logic        id_branch_taken;
  logic [31:0] id_branch_nt_pc;
  logic        intrlock_bubble;
  logic        ex_stall;
  logic [31:0] ex_rs1_val;
  logic [31:0] ex_rs2_val;
  logic        stat_clr;
  logic        ex_branch_flush;
  logic [31:0] ex_branch_pc;
  logic        ex_branch_taken;
  logic        ex_br_illegal;
  logic [15:0] stat_br_cnt;
  logic [15:0] stat_mis_cnt;

  branch_resolve dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_is_branch    (id_is_branch),
    .id_funct3       (id_funct3),
    .id_branch_taken (id_branch_taken),
    .id_branch_nt_pc (id_branch_nt_pc),
    .intrlock_bubble (intrlock_bubble),
    .ex_stall        (ex_stall),
    .ex_rs1_val      (ex_rs1_val),
    .ex_rs2_val      (ex_rs2_val),
    .stat_clr        (stat_clr),
    .ex_branch_flush (ex_branch_flush),
    .ex_branch_pc    (ex_branch_pc),
    .ex_branch_taken (ex_branch_taken),
    .ex_br_illegal   (ex_br_illegal),
    .stat_br_cnt     (stat_br_cnt),
    .stat_mis_cnt    (stat_mis_cnt)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The EX branch is described by what was loaded and how many cycles it
  // has been sitting in EX; it may only redirect in its first EX cycle.
  logic        m_vld;
  logic [2:0]  m_f3;
  logic        m_pred;
  logic [31:0] m_alt;
  int          m_age;
  int          m_br;
  int          m_mis;

  function automatic logic ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = (a >= 32'h8000_0000) ? longint'(a) - 64'sd4294967296 : longint'(a);
    sb = (b >= 32'h8000_0000) ? longint'(b) - 64'sd4294967296 : longint'(b);
    case (f)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return longint'(a) < longint'(b);
      3'd7:    return longint'(a) >= longint'(b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [2:0] f);
    return !(f == 3'd2 || f == 3'd3);
  endfunction

  function automatic logic ref_flush();
    return m_vld && ref_legal(m_f3) && (ref_cond(m_f3, ex_rs1_val, ex_rs2_val) != m_pred)
           && (m_age == 0);
  endfunction

  task automatic model_clear();
    m_vld = 1'b0; m_f3 = 3'd0; m_pred = 1'b0; m_alt = 32'd0;
    m_age = 0; m_br = 0; m_mis = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    id_is_branch    = 1'b0;
    id_funct3       = 3'd0;
    id_branch_taken = 1'b0;
    id_branch_nt_pc = 32'd0;
    intrlock_bubble = 1'b0;
    ex_stall        = 1'b0;
    ex_rs1_val      = 32'd0;
    ex_rs2_val      = 32'd0;
    stat_clr        = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic settle_check();
    logic c;
    #2;
    c = ref_cond(m_f3, ex_rs1_val, ex_rs2_val);
    check("flush",   {31'd0, ex_branch_flush}, {31'd0, ref_flush()});
    check("pc",      ex_branch_pc, m_vld ? m_alt : 32'd0);
    check("taken",   {31'd0, ex_branch_taken}, {31'd0, m_vld & c});
    check("illegal", {31'd0, ex_br_illegal}, {31'd0, m_vld & ~ref_legal(m_f3)});
    check("br_cnt",  {16'd0, stat_br_cnt}, m_br);
    check("mis_cnt", {16'd0, stat_mis_cnt}, m_mis);
  endtask

  // Advance one clock, updating the model from the inputs seen at the edge.
  task automatic tick();
    logic fl, c, ev;
    fl = ref_flush();
    c  = ref_cond(m_f3, ex_rs1_val, ex_rs2_val);
    ev = m_vld && ref_legal(m_f3) && !ex_stall;
    @(posedge clk);
    if (stat_clr) begin
      m_br = 0; m_mis = 0;
    end else if (ev) begin
      if (m_br < 65535) m_br++;
      if (c != m_pred && m_mis < 65535) m_mis++;
    end
    if (!ex_stall) begin
      m_vld  = id_is_branch && !fl && !intrlock_bubble;
      m_f3   = id_funct3;
      m_pred = id_branch_taken;
      m_alt  = id_branch_nt_pc;
      m_age  = 0;
    end else begin
      m_age++;
    end
    @(negedge clk);
  endtask

  task automatic load_branch(input logic [2:0] f, input logic p, input logic [31:0] alt);
    set_idle();
    id_is_branch    = 1'b1;
    id_funct3       = f;
    id_branch_taken = p;
    id_branch_nt_pc = alt;
    settle_check();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flush"},   {31'd0, ex_branch_flush}, 32'd0);
    check({tag, "_pc"},      ex_branch_pc, 32'd0);
    check({tag, "_taken"},   {31'd0, ex_branch_taken}, 32'd0);
    check({tag, "_illegal"}, {31'd0, ex_br_illegal}, 32'd0);
    check({tag, "_br_cnt"},  {16'd0, stat_br_cnt}, 32'd0);
    check({tag, "_mis_cnt"}, {16'd0, stat_mis_cnt}, 32'd0);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]  f3;
    logic        pred;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] alt;
    logic        exp_taken;
    logic        exp_flush;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int br0, mis0, flushes;

    vecs[0] = '{3'b000, 1'b0, 32'd5,          32'd5,          32'h100, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{3'b100, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'h200, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'b110, 1'b1, 32'hFFFF_FFFF,  32'd1,          32'h300, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3'b001, 1'b0, 32'd7,          32'd7,          32'h400, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{3'b101, 1'b0, 32'h8000_0000,  32'd0,          32'h500, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{3'b111, 1'b0, 32'h8000_0000,  32'd0,          32'h600, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{3'b010, 1'b1, 32'd1,          32'd2,          32'h700, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{3'b011, 1'b0, 32'd3,          32'd3,          32'h800, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{3'b100, 1'b0, 32'd1,          32'hFFFF_FFFF,  32'h900, 1'b0, 1'b0, 1'b0};

    // Reset state.
    set_idle();
    model_clear();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    settle_check();
    tick();

    // Vector table: load in one cycle, resolve in the next.
    for (int i = 0; i < 9; i++) begin
      load_branch(vecs[i].f3, vecs[i].pred, vecs[i].alt);
      set_idle();
      ex_rs1_val = vecs[i].rs1;
      ex_rs2_val = vecs[i].rs2;
      settle_check();
      check($sformatf("tbl%0d_taken", i), {31'd0, ex_branch_taken}, {31'd0, vecs[i].exp_taken});
      check($sformatf("tbl%0d_flush", i), {31'd0, ex_branch_flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("tbl%0d_ill", i),   {31'd0, ex_br_illegal},   {31'd0, vecs[i].exp_ill});
      check($sformatf("tbl%0d_pc", i),    ex_branch_pc, vecs[i].alt);
      tick();
      if (i == 0) begin
        check("beq_br_cnt",  {16'd0, stat_br_cnt},  32'd1);
        check("beq_mis_cnt", {16'd0, stat_mis_cnt}, 32'd1);
      end
    end
    check("tbl_br_total",  {16'd0, stat_br_cnt},  32'd7);
    check("tbl_mis_total", {16'd0, stat_mis_cnt}, 32'd3);

    // Mispredict held in EX for 3 cycles: one flush pulse, count on release.
    load_branch(3'b000, 1'b0, 32'h444);
    set_idle();
    ex_rs1_val = 32'd9;
    ex_rs2_val = 32'd9;
    ex_stall   = 1'b1;
    br0 = m_br;
    mis0 = m_mis;
    flushes = 0;
    for (int k = 0; k < 3; k++) begin
      settle_check();
      if (ex_branch_flush) flushes++;
      check("stall_br_hold", {16'd0, stat_br_cnt}, br0);
      tick();
    end
    ex_stall = 1'b0;
    settle_check();
    if (ex_branch_flush) flushes++;
    tick();
    check("stall_flush_pulses", flushes, 32'd1);
    check("stall_br_release",   {16'd0, stat_br_cnt},  br0 + 1);
    check("stall_mis_release",  {16'd0, stat_mis_cnt}, mis0 + 1);

    // Squash cases: flush+bubble, flush alone, bubble alone.
    for (int c = 0; c < 3; c++) begin
      if (c < 2) load_branch(3'b000, 1'b0, 32'h555);
      set_idle();
      ex_rs1_val      = 32'd4;
      ex_rs2_val      = 32'd4;
      id_is_branch    = 1'b1;
      id_funct3       = 3'b001;
      id_branch_nt_pc = 32'h777;
      intrlock_bubble = (c != 1);
      settle_check();
      tick();
      set_idle();
      ex_rs1_val = 32'd1;
      settle_check();
      check($sformatf("squash%0d_flush", c), {31'd0, ex_branch_flush}, 32'd0);
      check($sformatf("squash%0d_taken", c), {31'd0, ex_branch_taken}, 32'd0);
      check($sformatf("squash%0d_pc", c),    ex_branch_pc, 32'd0);
      tick();
    end

    // Reset in the middle of a stalled mispredicted branch.
    load_branch(3'b000, 1'b0, 32'h666);
    set_idle();
    ex_rs1_val = 32'd2;
    ex_rs2_val = 32'd2;
    ex_stall   = 1'b1;
    settle_check();
    tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    settle_check();
    tick();
    ex_stall = 1'b0;
    settle_check();
    check("rst_mid_no_flush", {31'd0, ex_branch_flush}, 32'd0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      id_is_branch    = ($urandom_range(0, 1) == 1);
      id_funct3       = 3'($urandom_range(0, 7));
      id_branch_taken = ($urandom_range(0, 1) == 1);
      id_branch_nt_pc = $urandom;
      intrlock_bubble = ($urandom_range(0, 4) == 0);
      ex_stall        = ($urandom_range(0, 3) == 0);
      stat_clr        = ($urandom_range(0, 49) == 0);
      ex_rs1_val      = pick_val();
      ex_rs2_val      = ($urandom_range(0, 3) == 0) ? ex_rs1_val : pick_val();
      settle_check();
      tick();
    end

    // Saturation: stream correctly predicted branches back to back.
    set_idle();
    id_is_branch    = 1'b1;
    id_funct3       = 3'b000;
    id_branch_nt_pc = 32'h888;
    ex_rs1_val      = 32'd1;
    ex_rs2_val      = 32'd2;
    repeat (65540) tick();
    settle_check();
    check("sat_br_cnt", {16'd0, stat_br_cnt}, 32'hFFFF);
    tick();
    check("sat_br_hold", {16'd0, stat_br_cnt}, 32'hFFFF);

    // Clear wins over a mispredicting retire in the same cycle.
    set_idle();
    ex_rs1_val = 32'd3;
    ex_rs2_val = 32'd3;
    stat_clr   = 1'b1;
    settle_check();
    check("clr_flush", {31'd0, ex_branch_flush}, 32'd1);
    tick();
    set_idle();
    settle_check();
    check("clr_br_cnt",  {16'd0, stat_br_cnt},  32'd0);
    check("clr_mis_cnt", {16'd0, stat_mis_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
